sequence_generator: RTL and testbench

SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

---
 rtl/seq_pkg.sv | 14 +
 rtl/seq_bit_counter.sv | 34 +++
 rtl/sequence_generator.sv | 134 +++++++++++++
 tb/tb_sequence_generator.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and default sizing for the serial sequence generator.
package seq_pkg;

  localparam int unsigned SEQ_WIDTH_DEF = 8;
  localparam int unsigned SEQ_LW_DEF    = 4;
  localparam int unsigned SEQ_RPT_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/seq_bit_counter.sv
// Loadable down-counter that saturates at zero; used for both bit and pass counts.
module seq_bit_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/sequence_generator.sv
// Serialises a captured pattern MSB-first, repeating it rpt extra times,
// then pulses done for one cycle.
module sequence_generator
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH = SEQ_WIDTH_DEF,
  parameter int unsigned LW    = SEQ_LW_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [WIDTH-1:0]     pattern,
  input  logic [LW-1:0]        len,
  input  logic [SEQ_RPT_W-1:0] rpt,
  input  logic                 abort,
  output logic                 x,
  output logic                 x_valid,
  output logic                 busy,
  output logic                 done
);

  seq_state_e state_q, state_d;

  logic             accept, last_bit, wrap;
  logic             bit_zero, pass_zero;
  logic             bit_load, bit_dec, pass_load, pass_dec;
  logic [LW-1:0]    eff_len, len_q, len_d, bit_load_val;
  logic [WIDTH-1:0] aligned, pat_q, pat_d, sh_q, sh_d;
  logic             x_q, x_d, xv_q, xv_d;

  // Left-align the pattern so the first bit to send always sits at the MSB.
  always_comb begin
    eff_len = len;
    if ((len == '0) || (len > LW'(WIDTH))) begin
      eff_len = LW'(WIDTH);
    end
    aligned = pattern << (LW'(WIDTH) - eff_len);
  end

  always_comb begin
    accept       = (state_q == IDLE) && start_valid;
    last_bit     = (state_q == SEND) && bit_zero && pass_zero;
    wrap         = (state_q == SEND) && bit_zero && !pass_zero;
    bit_load     = accept || (wrap && !abort);
    bit_load_val = accept ? (eff_len - LW'(1)) : (len_q - LW'(1));
    bit_dec      = (state_q == SEND) && !abort && !bit_zero;
    pass_load    = accept;
    pass_dec     = wrap && !abort;
  end

  seq_bit_counter #(.W(LW)) u_bit_cnt (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .load_i     (bit_load),
    .load_val_i (bit_load_val),
    .dec_i      (bit_dec),
    .zero_o     (bit_zero)
  );

  seq_bit_counter #(.W(SEQ_RPT_W)) u_pass_cnt (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .load_i     (pass_load),
    .load_val_i (rpt),
    .dec_i      (pass_dec),
    .zero_o     (pass_zero)
  );

  always_comb begin
    x_d   = 1'b0;
    xv_d  = 1'b0;
    sh_d  = sh_q;
    pat_d = pat_q;
    len_d = len_q;
    if (accept) begin
      x_d   = aligned[WIDTH-1];
      xv_d  = 1'b1;
      sh_d  = aligned << 1;
      pat_d = aligned;
      len_d = eff_len;
    end else if ((state_q == SEND) && !abort && !last_bit) begin
      xv_d = 1'b1;
      if (wrap) begin
        x_d  = pat_q[WIDTH-1];
        sh_d = pat_q << 1;
      end else begin
        x_d  = sh_q[WIDTH-1];
        sh_d = sh_q << 1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      x_q     <= 1'b0;
      xv_q    <= 1'b0;
      sh_q    <= '0;
      pat_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      xv_q    <= xv_d;
      sh_q    <= sh_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_valid) state_d = SEND;
      SEND: begin
        if (abort)         state_d = IDLE;
        else if (last_bit) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // reset_n gates ready so it stays low while reset is held.
  always_comb begin
    start_ready = (state_q == IDLE) && reset_n;
    busy        = (state_q != IDLE);
    done        = (state_q == DONE);
    x           = x_q;
    x_valid     = xv_q;
  end

endmodule

// File: tb/tb_sequence_generator.sv
// Scoreboard bench for sequence_generator: expected bits are queued at start, popped as x_valid bits appear.
module tb_sequence_generator;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start_valid;
  logic       start_ready;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [3:0] rpt;
  logic       abort;
  logic       x, x_valid, busy, done;

  bit exp_q[$];
  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  sequence_generator #(.WIDTH(8), .LW(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .pattern     (pattern),
    .len         (len),
    .rpt         (rpt),
    .abort       (abort),
    .x           (x),
    .x_valid     (x_valid),
    .busy        (busy),
    .done        (done)
  );

  // Monitor: pops one expected bit per valid cycle, checks x is 0 otherwise.
  always @(negedge clk) begin
    bit e;
    if (reset_n) begin
      if (done) done_cnt++;
      checks++;
      if (x_valid) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_bit: got x_valid=1 x=%0b, required no valid bit", x);
        end else begin
          e = exp_q.pop_front();
          if (x !== e) begin
            errors++;
            $display("FAIL serial_bit: got x=%0b, required %0b", x, e);
          end
        end
      end else if (x !== 1'b0) begin
        errors++;
        $display("FAIL x_idle_zero: got x=%0b, required 0", x);
      end
    end
  end

  function automatic int eff_len(input logic [3:0] l);
    return ((l == 4'd0) || (l > 4'd8)) ? 8 : int'(l);
  endfunction

  task automatic push_expected(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
    int el;
    el = eff_len(l);
    for (int k = 0; k <= int'(r); k++)
      for (int b = el - 1; b >= 0; b--)
        exp_q.push_back(p[b]);
  endtask

  // Entered and left at posedge+1 with the DUT in IDLE.
  task automatic run_transfer(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                              input bit hold, input bit ab, input string name);
    int el, cyc, d0;
    el = eff_len(l);
    d0 = done_cnt;
    push_expected(p, l, r);
    pattern = p; len = l; rpt = r; start_valid = 1'b1; abort = ab;
    checks++;
    if (start_ready !== 1'b1) begin
      errors++; $display("FAIL %s_ready_before: got %0b, required 1", name, start_ready);
    end
    @(posedge clk); #1;
    start_valid = hold; abort = 1'b0;
    pattern = ~p; len = 4'd1; rpt = 4'd0;
    cyc = 1;
    checks++;
    if ({busy, start_ready, x_valid} !== 3'b101) begin
      errors++; $display("FAIL %s_first_cycle: got busy/ready/valid=%b, required 101", name, {busy, start_ready, x_valid});
    end
    while (done !== 1'b1 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    start_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || cyc != el * (int'(r) + 1) + 1) begin
      errors++; $display("FAIL %s_done_cycle: got done=%0b at cycle %0d, required cycle %0d", name, done, cyc, el * (int'(r) + 1) + 1);
    end
    checks++;
    if ({x_valid, start_ready, busy} !== 3'b001) begin
      errors++; $display("FAIL %s_done_state: got valid/ready/busy=%b, required 001", name, {x_valid, start_ready, busy});
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL %s_bits_left: got %0d unsent bits, required 0", name, exp_q.size());
    end
    exp_q.delete();
    @(posedge clk); #1;
    checks++;
    if ({done, start_ready, busy} !== 3'b010) begin
      errors++; $display("FAIL %s_after_done: got done/ready/busy=%b, required 010", name, {done, start_ready, busy});
    end
    checks++;
    if (done_cnt != d0 + 1) begin
      errors++; $display("FAIL %s_done_pulses: got %0d, required 1", name, done_cnt - d0);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start_valid = 1'b0; abort = 1'b0;
    pattern = '0; len = '0; rpt = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({x, x_valid, busy, done, start_ready} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs: got %b, required 00000", {x, x_valid, busy, done, start_ready});
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (start_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_release: got ready=%0b busy=%0b, required 1 0", start_ready, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    run_transfer(8'b0000_0110, 4'd3, 4'd0, 1'b0, 1'b0, "single");
  endtask

  task automatic test_repeat();
    run_transfer(8'b0000_0101, 4'd3, 4'd2, 1'b0, 1'b0, "repeat");
  endtask

  task automatic test_len_limits();
    run_transfer(8'hA5, 4'd0,  4'd0, 1'b0, 1'b0, "len0");
    run_transfer(8'hA5, 4'd12, 4'd0, 1'b0, 1'b0, "len12");
    run_transfer(8'h96, 4'd8,  4'd1, 1'b0, 1'b0, "len8");
    run_transfer(8'h01, 4'd1,  4'd3, 1'b0, 1'b0, "len1");
  endtask

  task automatic test_abort();
    int d0;
    d0 = done_cnt;
    exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    pattern = 8'hA5; len = 4'd8; rpt = 4'd0; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if ({x_valid, done, busy, start_ready} !== 4'b0001) begin
      errors++; $display("FAIL abort_state: got valid/done/busy/ready=%b, required 0001", {x_valid, done, busy, start_ready});
    end
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (exp_q.size() != 0 || done_cnt != d0) begin
      errors++; $display("FAIL abort_no_done: got %0d bits left %0d done pulses, required 0 0", exp_q.size(), done_cnt - d0);
    end
    exp_q.delete();
    run_transfer(8'h3C, 4'd8, 4'd1, 1'b0, 1'b0, "after_abort");
  endtask

  task automatic test_reset_mid();
    push_expected(8'hA5, 4'd8, 4'd3);
    pattern = 8'hA5; len = 4'd8; rpt = 4'd3; start_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (start_ready !== 1'b0) begin
      errors++; $display("FAIL midreset_ready_busy: got %0b, required 0", start_ready);
    end
    @(negedge clk); #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({x, x_valid, busy, done, start_ready} !== 5'b0) begin
      errors++; $display("FAIL midreset_outputs: got %b, required 00000", {x, x_valid, busy, done, start_ready});
    end
    exp_q.delete();
    start_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    checks++;
    if ({start_ready, busy, done} !== 3'b100) begin
      errors++; $display("FAIL midreset_release: got ready/busy/done=%b, required 100", {start_ready, busy, done});
    end
    @(posedge clk); #1;
    run_transfer(8'h5A, 4'd5, 4'd2, 1'b1, 1'b0, "hold_start");
  endtask

  task automatic test_back_to_back();
    run_transfer(8'hC3, 4'd6, 4'd1, 1'b0, 1'b1, "abort_with_start");
    run_transfer(8'h81, 4'd8, 4'd0, 1'b0, 1'b0, "b2b_second");
  endtask

  initial begin
    test_reset();
    test_single();
    test_repeat();
    test_len_limits();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
